// File: rtl/hdc_dataset_sequencer.sv
// rtl/hdc_dataset_sequencer.sv - train/test dataset sequencer for the HDC datapath
// Optional accuracy counter enabled by macro HDC_SEQ_ACCURACY_EN.
module hdc_dataset_sequencer #(
   parameter int TRAIN_COUNT = 6238,
   parameter int TEST_COUNT  = 1559,
   parameter int CLASS_COUNT = 26
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic        go,
   input  logic        sample_valid,
   input  logic [4:0]  sample_label,
   input  logic        encoding_done,
   input  logic        class_gen_done,
   input  logic        checking_inference,
   input  logic [4:0]  class_inference,
   output logic        sample_ready,
   output logic        start_hdc,
   output logic        start_mapping,
   output logic [4:0]  class_select_bits,
   output logic        start_binarizing,
   output logic        training_dataset_finished,
   output logic        testing_dataset_finished,
   output logic [15:0] sample_index,
   output logic [15:0] correct_count,
   output logic        label_error,
   output logic        seq_busy,
   output logic        seq_done
);

   typedef enum logic [3:0] {
      IDLE, KICK, TR_WAIT, TR_MAP, TR_ENC, BIN, TS_WAIT, TS_MAP, TS_INF, DONE
   } state_t;

   localparam logic [15:0] TRAIN_N   = 16'(TRAIN_COUNT);
   localparam logic [15:0] TEST_N    = 16'(TEST_COUNT);
   localparam logic [5:0]  CLASS_LIM = 6'(CLASS_COUNT);

   state_t state, state_nx;

   logic ready_q, bin_q;
   logic label_bad, wait_ok;
   logic take, bad_take, restart, bin_entry, bin_exit, done_entry, infer_evt;

   // A label-error consume leaves us in WAIT; the ready_q guard stops the
   // still-held sample_valid from being consumed twice.
   assign wait_ok   = sample_valid && !ready_q;
   assign label_bad = ({1'b0, sample_label} >= CLASS_LIM);

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst)
         state <= IDLE;
      else if (en)
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      take       = 1'b0;
      bad_take   = 1'b0;
      restart    = 1'b0;
      bin_entry  = 1'b0;
      bin_exit   = 1'b0;
      done_entry = 1'b0;
      infer_evt  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (go) begin
               state_nx = KICK;
               restart  = 1'b1;
            end
         end
         KICK: state_nx = TR_WAIT;
         TR_WAIT: begin
            if (wait_ok) begin
               if (label_bad) begin
                  bad_take = 1'b1;
               end else begin
                  take     = 1'b1;
                  state_nx = TR_MAP;
               end
            end
         end
         TR_MAP: state_nx = TR_ENC;
         TR_ENC: begin
            if (encoding_done) begin
               if (sample_index == TRAIN_N) begin
                  state_nx  = BIN;
                  bin_entry = 1'b1;
               end else begin
                  state_nx = TR_WAIT;
               end
            end
         end
         BIN: begin
            if (class_gen_done) begin
               state_nx = TS_WAIT;
               bin_exit = 1'b1;
            end
         end
         TS_WAIT: begin
            if (wait_ok) begin
               if (label_bad) begin
                  bad_take = 1'b1;
               end else begin
                  take     = 1'b1;
                  state_nx = TS_MAP;
               end
            end
         end
         TS_MAP: state_nx = TS_INF;
         TS_INF: begin
            if (checking_inference) begin
               infer_evt = 1'b1;
               if (sample_index == TEST_N) begin
                  state_nx   = DONE;
                  done_entry = 1'b1;
               end else begin
                  state_nx = TS_WAIT;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         ready_q                   <= 1'b0;
         bin_q                     <= 1'b0;
         sample_index              <= 16'd0;
         class_select_bits         <= 5'd0;
         label_error               <= 1'b0;
         training_dataset_finished <= 1'b0;
         testing_dataset_finished  <= 1'b0;
      end else if (en) begin
         ready_q <= take | bad_take;
         bin_q   <= bin_entry;
         if (restart) begin
            sample_index              <= 16'd0;
            label_error               <= 1'b0;
            training_dataset_finished <= 1'b0;
            testing_dataset_finished  <= 1'b0;
         end
         if (take) begin
            sample_index      <= sample_index + 16'd1;
            class_select_bits <= sample_label;
         end
         if (bad_take)
            label_error <= 1'b1;
         if (bin_entry)
            training_dataset_finished <= 1'b1;
         if (bin_exit)
            sample_index <= 16'd0;
         if (done_entry)
            testing_dataset_finished <= 1'b1;
      end
   end

   // Pulses are gated by en so a frozen sequencer never repeats them.
   assign sample_ready     = ready_q & en;
   assign start_binarizing = bin_q & en;
   assign start_hdc        = en & (state == KICK);
   assign start_mapping    = en & ((state == TR_MAP) || (state == TS_MAP));
   assign seq_busy         = (state != IDLE) && (state != DONE);
   assign seq_done         = (state == DONE);

`ifdef HDC_SEQ_ACCURACY_EN
   logic [15:0] correct_q;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         correct_q <= 16'd0;
      end else if (en) begin
         if (restart)
            correct_q <= 16'd0;
         else if (infer_evt && (class_inference == class_select_bits) &&
                  (correct_q != 16'hFFFF))
            correct_q <= correct_q + 16'd1;
      end
   end

   assign correct_count = correct_q;
`else
   logic unused_accuracy;

   assign unused_accuracy = ^{class_inference, infer_evt};
   assign correct_count   = 16'd0;
`endif

endmodule
